// File: rtl/alu_seq_driver_pkg.sv
// ---------------------------------------------------------------------------
// alu_seq_driver_pkg : shared ALU defaults, driver FSM encodings, counter width
// Revision 1.0
// ---------------------------------------------------------------------------
`default_nettype none

package alu_seq_driver_pkg;

  localparam int C_ALU_ANCHO_DEFAULT = 4;
  localparam int C_OP_COUNT_W        = 8;

  localparam logic [1:0] ST_IDLE  = 2'b00;
  localparam logic [1:0] ST_DRIVE = 2'b01;
  localparam logic [1:0] ST_RESP  = 2'b10;

endpackage

`default_nettype wire

// File: rtl/alu_seq_driver.sv
// ---------------------------------------------------------------------------
// alu_seq_driver : sequences one command through an external combinational
//                  ALU unit and holds the captured result for a consumer
// Revision 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module alu_seq_driver
  import alu_seq_driver_pkg::*;
#(
  parameter int ancho = C_ALU_ANCHO_DEFAULT
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    cmd_valid,
  output logic                    cmd_ready,
  input  logic [ancho-1:0]        cmd_a,
  input  logic [ancho-1:0]        cmd_b,
  input  logic                    cmd_sel,
  output logic [ancho-1:0]        alu_a,
  output logic [ancho-1:0]        alu_b,
  output logic                    alu_flag,
  input  logic [ancho-1:0]        alu_result,
  output logic                    rsp_valid,
  input  logic                    rsp_ready,
  output logic [ancho-1:0]        rsp_data,
  output logic                    rsp_zero,
  output logic [C_OP_COUNT_W-1:0] op_count
);

  logic [1:0]              r_state;
  logic [ancho-1:0]        r_alu_a;
  logic [ancho-1:0]        r_alu_b;
  logic                    r_alu_flag;
  logic [ancho-1:0]        r_rsp_data;
  logic                    r_rsp_zero;
  logic [C_OP_COUNT_W-1:0] r_op_count;

  // Handshake outputs decode state only, so reset forces them immediately.
  assign cmd_ready = (r_state == ST_IDLE);
  assign rsp_valid = (r_state == ST_RESP);
  assign alu_a     = r_alu_a;
  assign alu_b     = r_alu_b;
  assign alu_flag  = r_alu_flag;
  assign rsp_data  = r_rsp_data;
  assign rsp_zero  = r_rsp_zero;
  assign op_count  = r_op_count;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= ST_IDLE;
      r_alu_a    <= '0;
      r_alu_b    <= '0;
      r_alu_flag <= 1'b0;
      r_rsp_data <= '0;
      r_rsp_zero <= 1'b1;
      r_op_count <= '0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (cmd_valid) begin
            r_state    <= ST_DRIVE;
            r_alu_a    <= cmd_a;
            r_alu_b    <= cmd_b;
            r_alu_flag <= cmd_sel;
          end
        end
        // The ALU has had a full cycle to settle on the registered operands.
        ST_DRIVE: begin
          r_state    <= ST_RESP;
          r_rsp_data <= alu_result;
          r_rsp_zero <= (alu_result == '0);
        end
        ST_RESP: begin
          if (rsp_ready) begin
            r_state    <= ST_IDLE;
            r_op_count <= r_op_count + C_OP_COUNT_W'(1);
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

endmodule

`default_nettype wire
